// File: rtl/pipelined_borrow_subtractor_if.sv
// Operand/result handshake bundle for the pipelined borrow subtractor.
// The master offers operands and accepts results; the slave is the pipeline.
interface pipelined_borrow_subtractor_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/pipelined_borrow_subtractor.sv
// Five-stage 16-bit a - b - bin subtractor; each stage resolves one bit segment and
// hands its borrow to the next stage through a register. The whole pipe advances as one.
module pipelined_borrow_subtractor (
    input logic                          clk,
    input logic                          rst,
    pipelined_borrow_subtractor_if.slave bus
);
    localparam int NumStages = 5;
    localparam int SegLo [NumStages] = '{0, 2, 4, 7, 11};
    localparam int SegW  [NumStages] = '{2, 2, 3, 4, 5};

    logic                 adv;
    logic [NumStages-1:0] valid_q;
    logic [NumStages-1:0] borrow_q;
    logic [15:0]          diff_q [NumStages];
    logic [15:0]          a_q    [NumStages-1];
    logic [15:0]          b_q    [NumStages-1];
    logic                 ovf_q;

    logic [NumStages-1:0] valid_in;
    logic [NumStages-1:0] borrow_in;
    logic [NumStages-1:0] borrow_d;
    logic [15:0]          a_in    [NumStages];
    logic [15:0]          b_in    [NumStages];
    logic [15:0]          diff_in [NumStages];
    logic [15:0]          diff_d  [NumStages];
    logic [15:0]          a_d     [NumStages-1];
    logic [15:0]          b_d     [NumStages-1];
    logic [5:0]           seg_res [NumStages];
    logic                 ovf_d;

    // Ripple of a + ~b + ~bor over the low w bits; returns {borrow_out, diff_bits}.
    function automatic logic [5:0] seg_sub(input logic [4:0] x, input logic [4:0] y,
                                           input logic bor, input int w);
        logic [4:0] s;
        logic       c;
        logic       p;
        logic       g;
        s = '0;
        c = ~bor;
        for (int i = 0; i < 5; i++) begin
            if (i < w) begin
                p    = x[i] ^ ~y[i];
                g    = x[i] & ~y[i];
                s[i] = p ^ c;
                c    = g | (p & c);
            end
        end
        return {~c, s};
    endfunction

    always_comb begin
        adv          = bus.out_ready | ~valid_q[NumStages-1];
        valid_in[0]  = bus.in_valid;
        a_in[0]      = bus.a;
        b_in[0]      = bus.b;
        borrow_in[0] = bus.bin;
        diff_in[0]   = '0;
        for (int k = 1; k < NumStages; k++) begin
            valid_in[k]  = valid_q[k-1];
            a_in[k]      = a_q[k-1];
            b_in[k]      = b_q[k-1];
            borrow_in[k] = borrow_q[k-1];
            diff_in[k]   = diff_q[k-1];
        end
        for (int k = 0; k < NumStages; k++) begin
            seg_res[k]  = seg_sub(5'(a_in[k] >> SegLo[k]), 5'(b_in[k] >> SegLo[k]),
                                  borrow_in[k], SegW[k]);
            borrow_d[k] = seg_res[k][5];
            diff_d[k]   = diff_in[k] | (16'(seg_res[k][4:0]) << SegLo[k]);
        end
        // Only the operand bits of later segments travel on.
        for (int k = 0; k < NumStages - 1; k++) begin
            a_d[k] = a_in[k] & ~((16'd1 << (SegLo[k] + SegW[k])) - 16'd1);
            b_d[k] = b_in[k] & ~((16'd1 << (SegLo[k] + SegW[k])) - 16'd1);
        end
        ovf_d = (a_in[NumStages-1][15] ^ b_in[NumStages-1][15]) &
                (diff_d[NumStages-1][15] ^ a_in[NumStages-1][15]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            borrow_q <= '0;
            ovf_q    <= 1'b0;
            for (int k = 0; k < NumStages; k++) diff_q[k] <= '0;
            for (int k = 0; k < NumStages - 1; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q  <= valid_in;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            for (int k = 0; k < NumStages; k++) diff_q[k] <= diff_d[k];
            for (int k = 0; k < NumStages - 1; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = valid_q[NumStages-1];
    assign bus.diff      = diff_q[NumStages-1];
    assign bus.bout      = borrow_q[NumStages-1];
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/pipelined_borrow_subtractor.md
PIPELINED_BORROW_SUBTRACTOR -- requirements
Module: pipelined_borrow_subtractor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising clock edge only.
REQ-002 Port list (name  direction  width  meaning):
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  operand beat accepted when in_valid & in_ready
- a  input  16  minuend, unsigned / two's complement
- b  input  16  subtrahend
- bin  input  1  borrow-in, subtracted with b
- out_valid  output  1  result beat offered
- out_ready  input  1  downstream accepts when out_valid & out_ready
- diff  output  16  a - b - bin, modulo 2^16
- bout  output  1  borrow-out; 1 iff unsigned a < b + bin
- ovf  output  1  signed overflow of a - b - bin
REQ-003 No parameters; widths SHALL be fixed as listed.

Function
REQ-004 Difference SHALL be computed over five segments, one per pipeline stage: S1 = bits [1:0], S2 = [3:2], S3 = [6:4], S4 = [10:7], S5 = [15:11].
REQ-005 Each segment SHALL compute its slice combinationally with generate/propagate terms on a and ~b; the stage-to-stage borrow SHALL ripple only through a per-stage register.
REQ-006 Stage k SHALL register: valid bit, the borrow out of segment k, diff bits of segments 1..k, and the unprocessed a/b bits of segments k+1..5.
REQ-007 S1 SHALL use bin as its borrow-in; stage k>1 SHALL use the registered borrow of stage k-1.
REQ-008 Global advance: adv = out_ready | ~out_valid; in_ready SHALL equal adv combinationally.
REQ-009 When adv=1, every stage SHALL load from its predecessor; stage 1 SHALL load valid = in_valid and the new operands.
REQ-010 When adv=0, every stage register SHALL hold its value unchanged, including data of invalid stages.
REQ-011 Latency SHALL be exactly 5 cycles from the accepting edge to out_valid=1 with no stall; throughput SHALL be one beat per cycle while out_ready=1.
REQ-012 A stage whose valid bit is 0 SHALL be a bubble; bubbles SHALL propagate but need not collapse while stalled.
REQ-013 out_valid, diff, bout and ovf SHALL be driven directly from stage-5 registers.
REQ-014 bout SHALL be the inverted carry out of bit 15 of a + ~b + ~bin.
REQ-015 ovf SHALL be 1 iff a[15] != b[15] and diff[15] != a[15].
REQ-016 Results SHALL leave in acceptance order; no beat SHALL be dropped or duplicated under any out_ready pattern.
REQ-017 Simultaneous output handshake and input acceptance in one cycle SHALL both complete.
REQ-018 in_valid while in_ready=0 SHALL have no effect; a, b and bin need not be held by the source.
REQ-019 diff, bout and ovf SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-020 On rst=1 at a clock edge, all five stage valid bits SHALL clear to 0.
REQ-021 On the same edge, stage data, diff, bout and ovf SHALL clear to 0.
REQ-022 After reset, out_valid=0 and in_ready=1.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight beats; no result from them SHALL appear.
REQ-024 rst SHALL take priority over handshakes in the same cycle.

Verification
REQ-025 Directed case 1: a=0x0005, b=0x0003, bin=0, out_ready=1 -> 5 cycles later diff=0x0002, bout=0, ovf=0.
REQ-026 Directed case 2: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0; borrow ripples through all five stages.
REQ-027 Directed case 3: a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1.
REQ-028 Directed case 3 also: a=0x7FFF, b=0xFFFF, bin=1 -> diff=0x7FFF, bout=1, ovf=0.
REQ-029 Directed case 4: stream 8 back-to-back beats, out_ready=1 -> 8 consecutive out_valid cycles, correct order.
REQ-030 Directed case 4 also: hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, outputs frozen, zero loss after release.
REQ-031 Directed case 5: assert rst for 1 cycle with 3 beats in flight -> out_valid stays 0 until new beats are accepted and reach stage 5.
REQ-032 Directed case 6: 10^5 random beats with random in_valid/out_ready, checked against a reference model of {bout,diff} = {1'b0,a} - b - bin -> zero mismatches.
